// File: rtl/retire_trace_aligner.sv
// Retire/GPR-writeback trace aligner: queues retiring PCs until their GPR write
// (same-cycle or late) is known, then emits each PC with its write in one registered cycle.
module retire_trace_aligner #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rtu_retire_vld,
    input  logic [XLEN-1:0] rtu_retire_pc,
    input  logic [1:0]      rtu_retire_wb_sel,
    input  logic [4:0]      rtu_wb_index,
    input  logic [XLEN-1:0] rtu_wb_data,
    input  logic            late_wb_vld,
    input  logic [4:0]      late_wb_index,
    input  logic [XLEN-1:0] late_wb_data,
    output logic            biu_pad_retire,
    output logic [XLEN-1:0] biu_pad_retire_pc,
    output logic            biu_pad_wb_gpr_en,
    output logic [4:0]      biu_pad_wb_gpr_index,
    output logic [XLEN-1:0] biu_pad_wb_gpr_data,
    output logic            trace_full,
    output logic            trace_err
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic            has_wb;
        logic            late;
        logic            done;
        logic [4:0]      index;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t [DEPTH-1:0] q_q, q_d;
    logic [PW-1:0]      head_q, head_d, tail_q, tail_d;
    logic [PW:0]        count_q, count_d;
    logic               err_q, err_d;
    logic               out_vld_q, out_vld_d;
    logic [XLEN-1:0]    out_pc_q, out_pc_d;
    logic               out_en_q, out_en_d;
    logic [4:0]         out_idx_q, out_idx_d;
    logic [XLEN-1:0]    out_data_q, out_data_d;

    logic               full, pop, push, late_hit;
    logic [PW-1:0]      late_idx, scan_idx;
    entry_t             head_e, new_e;

    assign full   = (count_q == (PW+1)'(DEPTH));
    assign head_e = q_q[head_q];
    assign pop    = (count_q != '0) && head_e.done;
    // A full queue still accepts a retire when the head leaves at the same edge.
    assign push   = rtu_retire_vld && (!full || pop);

    // Oldest pending late entry; only entries already queued are candidates.
    always_comb begin
        late_hit = 1'b0;
        late_idx = '0;
        scan_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scan_idx = head_q + PW'(i);
            if (!late_hit && ((PW+1)'(i) < count_q) &&
                q_q[scan_idx].late && !q_q[scan_idx].done) begin
                late_hit = 1'b1;
                late_idx = scan_idx;
            end
        end
    end

    always_comb begin
        new_e        = '0;
        new_e.pc     = rtu_retire_pc;
        new_e.done   = 1'b1;
        case (rtu_retire_wb_sel)
            2'b01: begin
                new_e.has_wb = 1'b1;
                new_e.index  = rtu_wb_index;
                new_e.data   = rtu_wb_data;
            end
            2'b10: begin
                new_e.has_wb = 1'b1;
                new_e.late   = 1'b1;
                new_e.done   = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        q_d        = q_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        err_d      = err_q;
        out_vld_d  = 1'b0;
        out_pc_d   = out_pc_q;
        out_en_d   = out_en_q;
        out_idx_d  = out_idx_q;
        out_data_d = out_data_q;

        if (late_wb_vld) begin
            if (late_hit) begin
                q_d[late_idx].done  = 1'b1;
                q_d[late_idx].index = late_wb_index;
                q_d[late_idx].data  = late_wb_data;
            end else begin
                err_d = 1'b1;
            end
        end
        if (rtu_retire_vld && !push) err_d = 1'b1;

        if (pop) begin
            out_vld_d  = 1'b1;
            out_pc_d   = head_e.pc;
            out_en_d   = head_e.has_wb && (head_e.index != 5'd0);
            out_idx_d  = head_e.index;
            out_data_d = head_e.data;
            head_d     = head_q + PW'(1);
        end
        if (push) begin
            q_d[tail_q] = new_e;
            tail_d      = tail_q + PW'(1);
        end
        if (push && !pop)      count_d = count_q + (PW+1)'(1);
        else if (!push && pop) count_d = count_q - (PW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q        <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            err_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_pc_q   <= '0;
            out_en_q   <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
        end else begin
            q_q        <= q_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            err_q      <= err_d;
            out_vld_q  <= out_vld_d;
            out_pc_q   <= out_pc_d;
            out_en_q   <= out_en_d;
            out_idx_q  <= out_idx_d;
            out_data_q <= out_data_d;
        end
    end

    assign biu_pad_retire       = out_vld_q;
    assign biu_pad_retire_pc    = out_pc_q;
    assign biu_pad_wb_gpr_en    = out_en_q;
    assign biu_pad_wb_gpr_index = out_idx_q;
    assign biu_pad_wb_gpr_data  = out_data_q;
    assign trace_full           = full;
    assign trace_err            = err_q;
endmodule

// File: tb/tb_retire_trace_aligner.sv
// Directed bench for retire_trace_aligner: each step drives one cycle of inputs,
// advances to 1 time unit after the edge and checks the registered trace outputs.
module tb_retire_trace_aligner;
    logic        clk = 1'b0;
    logic        rst;
    logic        rtu_retire_vld;
    logic [31:0] rtu_retire_pc;
    logic [1:0]  rtu_retire_wb_sel;
    logic [4:0]  rtu_wb_index;
    logic [31:0] rtu_wb_data;
    logic        late_wb_vld;
    logic [4:0]  late_wb_index;
    logic [31:0] late_wb_data;
    logic        biu_pad_retire;
    logic [31:0] biu_pad_retire_pc;
    logic        biu_pad_wb_gpr_en;
    logic [4:0]  biu_pad_wb_gpr_index;
    logic [31:0] biu_pad_wb_gpr_data;
    logic        trace_full;
    logic        trace_err;

    int vectors = 0;
    int miscompares = 0;

    retire_trace_aligner #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .rtu_retire_vld(rtu_retire_vld), .rtu_retire_pc(rtu_retire_pc),
        .rtu_retire_wb_sel(rtu_retire_wb_sel), .rtu_wb_index(rtu_wb_index),
        .rtu_wb_data(rtu_wb_data), .late_wb_vld(late_wb_vld),
        .late_wb_index(late_wb_index), .late_wb_data(late_wb_data),
        .biu_pad_retire(biu_pad_retire), .biu_pad_retire_pc(biu_pad_retire_pc),
        .biu_pad_wb_gpr_en(biu_pad_wb_gpr_en), .biu_pad_wb_gpr_index(biu_pad_wb_gpr_index),
        .biu_pad_wb_gpr_data(biu_pad_wb_gpr_data), .trace_full(trace_full),
        .trace_err(trace_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rtu_retire_vld    = 1'b0;
        rtu_retire_pc     = '0;
        rtu_retire_wb_sel = 2'b00;
        rtu_wb_index      = '0;
        rtu_wb_data       = '0;
        late_wb_vld       = 1'b0;
        late_wb_index     = '0;
        late_wb_data      = '0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic [1:0] sel,
                          input logic [4:0] idx, input logic [31:0] data);
        idle();
        rtu_retire_vld    = 1'b1;
        rtu_retire_pc     = pc;
        rtu_retire_wb_sel = sel;
        rtu_wb_index      = idx;
        rtu_wb_data       = data;
    endtask

    task automatic late(input logic [4:0] idx, input logic [31:0] data);
        idle();
        late_wb_vld   = 1'b1;
        late_wb_index = idx;
        late_wb_data  = data;
    endtask

    task automatic expect_emit(input string tag, input logic [31:0] pc, input logic en,
                               input logic [4:0] idx, input logic [31:0] data);
        check({tag, ".retire"}, 32'(biu_pad_retire), 32'd1);
        check({tag, ".pc"}, biu_pad_retire_pc, pc);
        check({tag, ".en"}, 32'(biu_pad_wb_gpr_en), 32'(en));
        if (en) begin
            check({tag, ".idx"}, 32'(biu_pad_wb_gpr_index), 32'(idx));
            check({tag, ".data"}, biu_pad_wb_gpr_data, data);
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        idle();
        do_reset();
        check("rst.retire", 32'(biu_pad_retire), 32'd0);
        check("rst.pc", biu_pad_retire_pc, 32'd0);
        check("rst.full", 32'(trace_full), 32'd0);
        check("rst.err", 32'(trace_err), 32'd0);

        // 1: same-cycle write into an empty queue, two-cycle latency
        retire(32'h100, 2'b01, 5'd5, 32'hDEAD);
        tick(); idle();
        check("t1.c1.retire", 32'(biu_pad_retire), 32'd0);
        tick();
        expect_emit("t1.c2", 32'h100, 1'b1, 5'd5, 32'hDEAD);
        tick();
        check("t1.c3.retire", 32'(biu_pad_retire), 32'd0);
        check("t1.c3.pc_hold", biu_pad_retire_pc, 32'h100);

        // 2: late head blocks younger done entries
        retire(32'h200, 2'b10, 5'd0, 32'h0);
        tick(); retire(32'h204, 2'b00, 5'd0, 32'h0);
        tick(); retire(32'h208, 2'b01, 5'd6, 32'h1);
        tick(); idle();
        tick();
        check("t2.c4.blocked", 32'(biu_pad_retire), 32'd0);
        tick(); late(5'd7, 32'h77);
        tick(); idle();
        check("t2.c6.retire", 32'(biu_pad_retire), 32'd0);
        tick();
        expect_emit("t2.c7", 32'h200, 1'b1, 5'd7, 32'h77);
        tick();
        expect_emit("t2.c8", 32'h204, 1'b0, 5'd0, 32'h0);
        tick();
        expect_emit("t2.c9", 32'h208, 1'b1, 5'd6, 32'h1);
        tick();
        check("t2.c10.retire", 32'(biu_pad_retire), 32'd0);
        check("t2.err", 32'(trace_err), 32'd0);

        // 3: fill with late entries, overflow retire dropped
        for (int i = 0; i < 4; i++) begin
            retire(32'h400 + 32'(4 * i), 2'b10, 5'd0, 32'h0);
            tick();
        end
        idle();
        check("t3.full", 32'(trace_full), 32'd1);
        check("t3.err_before", 32'(trace_err), 32'd0);
        retire(32'h410, 2'b00, 5'd0, 32'h0);
        tick(); late(5'd1, 32'h11);
        check("t3.err_drop", 32'(trace_err), 32'd1);
        check("t3.full_kept", 32'(trace_full), 32'd1);
        tick(); late(5'd2, 32'h22);
        tick(); late(5'd3, 32'h33);
        expect_emit("t3.e0", 32'h400, 1'b1, 5'd1, 32'h11);
        check("t3.full_after_pop", 32'(trace_full), 32'd0);
        tick(); late(5'd4, 32'h44);
        expect_emit("t3.e1", 32'h404, 1'b1, 5'd2, 32'h22);
        tick(); idle();
        expect_emit("t3.e2", 32'h408, 1'b1, 5'd3, 32'h33);
        tick();
        expect_emit("t3.e3", 32'h40c, 1'b1, 5'd4, 32'h44);
        tick();
        check("t3.no_dropped", 32'(biu_pad_retire), 32'd0);
        check("t3.full_end", 32'(trace_full), 32'd0);

        do_reset();
        check("t4.err_cleared", 32'(trace_err), 32'd0);

        // 4: retire into a full queue at the edge its done head pops
        retire(32'h500, 2'b10, 5'd0, 32'h0);
        tick(); retire(32'h504, 2'b01, 5'd1, 32'h1);
        tick(); retire(32'h508, 2'b01, 5'd2, 32'h2);
        tick(); retire(32'h50c, 2'b01, 5'd3, 32'h3);
        tick(); late(5'd8, 32'h88);
        check("t4.full", 32'(trace_full), 32'd1);
        tick(); retire(32'h510, 2'b01, 5'd9, 32'h99);
        check("t4.full_head_done", 32'(trace_full), 32'd1);
        tick(); idle();
        expect_emit("t4.e0", 32'h500, 1'b1, 5'd8, 32'h88);
        check("t4.count4", 32'(trace_full), 32'd1);
        check("t4.err", 32'(trace_err), 32'd0);
        tick(); expect_emit("t4.e1", 32'h504, 1'b1, 5'd1, 32'h1);
        tick(); expect_emit("t4.e2", 32'h508, 1'b1, 5'd2, 32'h2);
        tick(); expect_emit("t4.e3", 32'h50c, 1'b1, 5'd3, 32'h3);
        tick(); expect_emit("t4.e4", 32'h510, 1'b1, 5'd9, 32'h99);
        tick();
        check("t4.idle", 32'(biu_pad_retire), 32'd0);
        check("t4.not_full", 32'(trace_full), 32'd0);
        check("t4.err_end", 32'(trace_err), 32'd0);

        // 5: orphan late write; x0 and reserved-sel writes suppressed
        late(5'd3, 32'h3);
        tick(); retire(32'h600, 2'b01, 5'd0, 32'h55);
        check("t5.err", 32'(trace_err), 32'd1);
        check("t5.no_emit", 32'(biu_pad_retire), 32'd0);
        tick(); retire(32'h604, 2'b11, 5'd4, 32'h66);
        tick(); idle();
        expect_emit("t5.x0", 32'h600, 1'b0, 5'd0, 32'h0);
        tick();
        expect_emit("t5.sel11", 32'h604, 1'b0, 5'd0, 32'h0);

        // 6: asynchronous reset with queued entries
        retire(32'h700, 2'b10, 5'd0, 32'h0);
        tick(); retire(32'h704, 2'b10, 5'd0, 32'h0);
        tick(); retire(32'h708, 2'b10, 5'd0, 32'h0);
        tick(); idle();
        #2 rst = 1'b1;
        #1;
        check("t6.async.pc", biu_pad_retire_pc, 32'd0);
        check("t6.async.full", 32'(trace_full), 32'd0);
        check("t6.async.err", 32'(trace_err), 32'd0);
        tick();
        rst = 1'b0;
        retire(32'h300, 2'b00, 5'd0, 32'h0);
        tick(); idle();
        tick();
        expect_emit("t6.e0", 32'h300, 1'b0, 5'd0, 32'h0);
        late(5'd7, 32'h7);
        tick(); idle();
        tick();
        check("t6.no_stale", 32'(biu_pad_retire), 32'd0);
        check("t6.orphan_err", 32'(trace_err), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
